// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester round-robin front end for a shared ALU.
// A granted request's operands are registered onto the ALU bus, held for
// SETTLE cycles, and the ALU result is captured and acknowledged.
// Optional build macro: ALU_ARB_DIVZ_EN adds divide-by-zero substitution
// (res=16'hFFFF, err=1) at capture; without it err is tied low.
module alu_arbiter #(
  parameter int unsigned SETTLE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        req1,
  input  logic [7:0]  a0,
  input  logic [7:0]  b0,
  input  logic [7:0]  a1,
  input  logic [7:0]  b1,
  input  logic [3:0]  cmd0,
  input  logic [3:0]  cmd1,
  output logic        ack0,
  output logic        ack1,
  output logic [15:0] res,
  output logic        res_id,
  output logic        res_vld,
  output logic        err,
  output logic        busy,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [3:0]  alu_cmd,
  output logic        alu_oe,
  input  logic [15:0] alu_d_out
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_cnt;
  logic        r_grant;
  logic        r_last;
  logic [7:0]  r_alu_a;
  logic [7:0]  r_alu_b;
  logic [3:0]  r_alu_cmd;
  logic [15:0] r_res;
  logic        r_res_id;
  logic        w_any;
  logic        w_grant;
  logic        w_capture;

  assign w_any     = req0 | req1;
  // On contention the requester not served last wins; otherwise the lone one.
  assign w_grant   = (req0 & req1) ? ~r_last : req1;
  assign w_capture = (r_state == S_EXEC) && (r_cnt == 4'(SETTLE - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (w_any)     w_next = S_EXEC;
      S_EXEC: if (w_capture) w_next = S_DONE;
      S_DONE:                w_next = S_IDLE;
      default:               w_next = S_IDLE;
    endcase
  end

  // Grant, round-robin pointer, operand registers and settle counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_grant   <= 1'b0;
      r_last    <= 1'b1;
      r_alu_a   <= '0;
      r_alu_b   <= '0;
      r_alu_cmd <= '0;
    end else if (r_state == S_IDLE && w_any) begin
      r_cnt     <= '0;
      r_grant   <= w_grant;
      r_last    <= w_grant;
      r_alu_a   <= w_grant ? a1 : a0;
      r_alu_b   <= w_grant ? b1 : b0;
      r_alu_cmd <= w_grant ? cmd1 : cmd0;
    end else if (r_state == S_EXEC) begin
      r_cnt <= r_cnt + 4'd1;
    end
  end

`ifdef ALU_ARB_DIVZ_EN
  logic r_err;

  // Result capture with divide-by-zero substitution
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res    <= '0;
      r_res_id <= 1'b0;
      r_err    <= 1'b0;
    end else if (w_capture) begin
      r_res_id <= r_grant;
      if (r_alu_cmd == 4'b0101 && r_alu_b == 8'h00) begin
        r_res <= '1;
        r_err <= 1'b1;
      end else begin
        r_res <= alu_d_out;
        r_err <= 1'b0;
      end
    end
  end

  assign err = r_err;
`else
  // Result capture, ALU output taken unmodified
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res    <= '0;
      r_res_id <= 1'b0;
    end else if (w_capture) begin
      r_res    <= alu_d_out;
      r_res_id <= r_grant;
    end
  end

  assign err = 1'b0;
`endif

  // State-decoded outputs
  always_comb begin
    alu_oe  = (r_state == S_EXEC);
    ack0    = (r_state == S_DONE) && !r_grant;
    ack1    = (r_state == S_DONE) &&  r_grant;
    res_vld = (r_state == S_DONE);
    busy    = (r_state != S_IDLE);
  end

  assign res     = r_res;
  assign res_id  = r_res_id;
  assign alu_a   = r_alu_a;
  assign alu_b   = r_alu_b;
  assign alu_cmd = r_alu_cmd;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus randomized traffic,
// checked against a transaction-level model of arbitration and results.
module tb_alu_arbiter;

  localparam int unsigned SETTLE = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req1;
  logic [7:0]  a0, b0, a1, b1;
  logic [3:0]  cmd0, cmd1;
  logic        ack0, ack1, res_id, res_vld, err, busy, alu_oe;
  logic [15:0] res, alu_d_out;
  logic [7:0]  alu_a, alu_b;
  logic [3:0]  alu_cmd;

  int checks = 0;
  int errors = 0;
  int last   = 1;
  int id;
  bit p0, p1, keep;
  logic [3:0] cmd_tab [8] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hF};

  alu_arbiter #(.SETTLE(SETTLE)) u_dut (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1), .cmd0(cmd0), .cmd1(cmd1),
    .ack0(ack0), .ack1(ack1), .res(res), .res_id(res_id), .res_vld(res_vld),
    .err(err), .busy(busy), .alu_a(alu_a), .alu_b(alu_b), .alu_cmd(alu_cmd),
    .alu_oe(alu_oe), .alu_d_out(alu_d_out)
  );

  always #5 clk = ~clk;

  // Shared ALU: ADD SUB MUL AND OR DIV XOR ..., BUF passes a.
  function automatic logic [15:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                        input logic [3:0] c);
    case (c)
      4'h0: return 16'(a) + 16'(b);
      4'h1: return 16'(a) - 16'(b);
      4'h2: return 16'(a) * 16'(b);
      4'h3: return 16'(a & b);
      4'h4: return 16'(a | b);
      4'h5: return (b == 8'h00) ? 16'h00FF : 16'(a / b);
      4'h6: return 16'(a ^ b);
      default: return 16'(a);
    endcase
  endfunction

  always_comb alu_d_out = alu_oe ? alu_f(alu_a, alu_b, alu_cmd) : 16'hzzzz;

  function automatic logic divz(input logic [7:0] b, input logic [3:0] c);
`ifdef ALU_ARB_DIVZ_EN
    return (c == 4'h5) && (b == 8'h00);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [15:0] exp_res(input logic [7:0] a, input logic [7:0] b,
                                          input logic [3:0] c);
    return divz(b, c) ? 16'hFFFF : alu_f(a, b, c);
  endfunction

  task automatic chk(input logic [31:0] obs, input logic [31:0] expv, input string tag);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Round-robin model: contention goes to whoever was not served last.
  task automatic pick(output int g);
    if (req0 && req1) g = 1 - last;
    else              g = req1 ? 1 : 0;
    last = g;
  endtask

  task automatic new_req(input int r);
    logic [7:0] a, b;
    logic [3:0] c;
    a = 8'($urandom);
    b = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
    c = cmd_tab[$urandom_range(0, 7)];
    if (r == 0) begin req0 = 1'b1; a0 = a; b0 = b; cmd0 = c; end
    else        begin req1 = 1'b1; a1 = a; b1 = b; cmd1 = c; end
  endtask

  logic [15:0] held_res;
  logic [7:0]  held_a;

  // From an IDLE-cycle point: wait for the ack and check the transaction.
  task automatic expect_op(input int g);
    int cyc;
    logic [7:0] ea, eb;
    logic [3:0] ec;
    ea = g ? a1 : a0;
    eb = g ? b1 : b0;
    ec = g ? cmd1 : cmd0;
    cyc = 0;
    while (!(ack0 | ack1) && cyc < 40) begin
      tick();
      cyc++;
      if (cyc == 1) begin
        chk(alu_oe, 1, "alu_oe_exec");
        chk({alu_a, alu_b, alu_cmd}, {ea, eb, ec}, "alu_bus");
      end
    end
    chk(cyc, SETTLE + 1, "latency");
    chk({ack1, ack0}, (g == 1) ? 2'b10 : 2'b01, "ack");
    chk(res_vld, 1, "res_vld");
    chk(res_id, g, "res_id");
    chk(res, exp_res(ea, eb, ec), "res");
    chk(err, divz(eb, ec), "err");
    chk(alu_oe, 0, "alu_oe_done");
    held_res = exp_res(ea, eb, ec);
    held_a   = ea;
  endtask

  // Cycle after the ack: single-cycle pulse, back in IDLE, outputs held.
  task automatic after_ack();
    tick();
    chk({ack1, ack0, res_vld, busy, alu_oe}, 0, "idle_outputs");
    chk(res, held_res, "res_hold");
    chk(alu_a, held_a, "alu_a_hold");
  endtask

  initial begin
    rst_n = 1'b0;
    {req0, req1} = 2'b00;
    {a0, b0, a1, b1} = '0;
    {cmd0, cmd1} = '0;
    repeat (2) tick();
    chk({ack1, ack0, res_vld, busy, alu_oe, err, res_id}, 0, "reset_flags");
    chk({res, alu_a, alu_b, alu_cmd}, 0, "reset_data");

    // Contention straight after reset: 0 first (MUL), then 1 (DIV).
    rst_n = 1'b1;
    req0 = 1'b1; a0 = 8'd255; b0 = 8'd255; cmd0 = 4'h2;
    req1 = 1'b1; a1 = 8'd9;   b1 = 8'd3;   cmd1 = 4'h5;
    pick(id); chk(id, 0, "model_first_grant");
    expect_op(id);
    chk(res, 16'hFE01, "mul_255");
    req0 = 1'b0;
    after_ack();
    pick(id); expect_op(id);
    chk({res_id, res}, {1'b1, 16'd3}, "div_9_3");
    req1 = 1'b0;
    after_ack();

    // Both held for four operations: alternation.
    new_req(0); new_req(1);
    for (int k = 0; k < 4; k++) begin
      pick(id); expect_op(id);
      new_req(id);
      after_ack();
    end
    {req0, req1} = 2'b00;

    // Single request: 200 + 100.
    req0 = 1'b1; a0 = 8'd200; b0 = 8'd100; cmd0 = 4'h0;
    pick(id); expect_op(id);
    chk(res, 16'd300, "add_300");
    req0 = 1'b0;
    after_ack();

    // Divide by zero, then ADD 1+1 clears err.
    req1 = 1'b1; a1 = 8'd7; b1 = 8'd0; cmd1 = 4'h5;
    pick(id); expect_op(id);
    a1 = 8'd1; b1 = 8'd1; cmd1 = 4'h0;
    after_ack();
    pick(id); expect_op(id);
    chk({err, res}, {1'b0, 16'd2}, "add_after_divz");
    req1 = 1'b0;
    after_ack();

    // Randomized traffic with held requests.
    p0 = 1'b0; p1 = 1'b0;
    for (int k = 0; k < 24; k++) begin
      if (!p0 && $urandom_range(0, 1) == 1) begin new_req(0); p0 = 1'b1; end
      if (!p1 && $urandom_range(0, 1) == 1) begin new_req(1); p1 = 1'b1; end
      if (!p0 && !p1) begin new_req(0); p0 = 1'b1; end
      pick(id); expect_op(id);
      keep = 1'($urandom_range(0, 1));
      if (id == 0) begin
        p0 = keep;
        if (keep) new_req(0); else req0 = 1'b0;
      end else begin
        p1 = keep;
        if (keep) new_req(1); else req1 = 1'b0;
      end
      after_ack();
    end
    {req0, req1} = 2'b00;
    tick();

    // Reset during the second EXEC cycle aborts; held req0 is re-arbitrated.
    req0 = 1'b1; a0 = 8'd12; b0 = 8'd34; cmd0 = 4'h6;
    tick(); tick();
    chk({busy, alu_oe}, 2'b11, "exec_before_abort");
    rst_n = 1'b0;
    #1;
    chk({ack1, ack0, res_vld, busy, alu_oe, err, res_id}, 0, "abort_flags");
    chk({res, alu_a, alu_b, alu_cmd}, 0, "abort_data");
    rst_n = 1'b1;
    last = 1;
    pick(id); expect_op(id);
    req0 = 1'b0;
    after_ack();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: SETTLE, 1, ALU settle time in EXEC cycles before result capture; legal range 1..15.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 req0 / req1  input  1  operation request from requester 0 / 1.
REQ-005 a0, b0 / a1, b1  input  8 each  operands of requester 0 / 1.
REQ-006 cmd0 / cmd1  input  4 each  ALU opcode of requester 0 / 1, using the team ALU encoding (ADD=0000 ... DIV=0101 ... BUF=1111).
REQ-007 ack0 / ack1  output  1  one-cycle completion pulse to requester 0 / 1.
REQ-008 res  output  16  captured ALU result.
REQ-009 res_id  output  1  requester index of the last captured result.
REQ-010 res_vld  output  1  one-cycle pulse; equals ack0 | ack1.
REQ-011 err  output  1  divide-by-zero flag for the last result (see Configuration).
REQ-012 busy  output  1  high in EXEC and DONE.
REQ-013 alu_a, alu_b  output  8 each; alu_cmd  output  4; alu_oe  output  1  drive the shared ALU.
REQ-014 alu_d_out  input  16  shared ALU result bus.

Function
REQ-015 FSM states: IDLE, EXEC, DONE.
REQ-016 IDLE: if any req is high, grant one requester, register its a/b/cmd into alu_a/alu_b/alu_cmd, load the settle counter with 0, go to EXEC; otherwise stay.
REQ-017 Arbitration: single req -> grant it; both high -> grant the requester not granted last (round-robin); pointer updates on every grant.
REQ-018 EXEC: alu_oe=1; the counter increments each cycle; in the cycle the count reaches SETTLE-1, capture alu_d_out into res and the grant into res_id, then go to DONE.
REQ-019 DONE: alu_oe=0; assert ack of the granted requester and res_vld for exactly one cycle; go to IDLE.
REQ-020 Latency: req sampled in IDLE cycle N -> ack in cycle N+SETTLE+1; throughput one operation per SETTLE+2 cycles.
REQ-021 Handshake: requester holds req, operands and cmd stable until its ack; req still high in the cycle after ack is a new request.
REQ-022 Operand and req changes during EXEC/DONE are ignored.
REQ-023 alu_a/alu_b/alu_cmd hold their last values outside EXEC; alu_oe is high only in EXEC.
REQ-024 res, res_id and err hold until the next capture; the arbiter never drives res to Z.
REQ-025 Width rule: res takes all 16 bits of alu_d_out unmodified, except as specified in REQ-029.

Reset
REQ-026 rst_n low: state=IDLE; counter=0; res=16'h0000; res_id=0; err=0; ack0=ack1=res_vld=busy=0; alu_a=alu_b=8'h00; alu_cmd=4'h0; alu_oe=0; round-robin pointer set so requester 0 wins the first contention.
REQ-027 Reset asserted during EXEC or DONE aborts the operation; no ack is produced for it, and after release a still-high req is arbitrated afresh.
REQ-028 After rst_n rises, the first grant can occur on the first rising edge.

Configuration
REQ-029 Macro ALU_ARB_DIVZ_EN defined: at capture, if alu_cmd=4'b0101 and alu_b=8'h00, set res=16'hFFFF and err=1; else res=alu_d_out and err=0.
REQ-030 Macro ALU_ARB_DIVZ_EN undefined: err is constant 0 and res=alu_d_out always; no divide check logic is present.

Verification
REQ-031 SETTLE=1, req0 with a0=200, b0=100, cmd0=ADD sampled in cycle 0 -> alu_oe=1 in cycle 1; ack0=res_vld=1 in cycle 2; res=16'd300; res_id=0.
REQ-032 req0 and req1 rise together after reset (a0=b0=255 MUL; a1=9, b1=3 DIV) -> requester 0 is served first with res=16'hFE01, then requester 1 with res=16'd3 and res_id=1; each ack is one cycle wide.
REQ-033 Both req held high for four operations -> grants alternate 0,1,0,1; there is no starvation.
REQ-034 With ALU_ARB_DIVZ_EN, req1 issues a1=7, b1=0, DIV -> res=16'hFFFF and err=1; the next ADD 1+1 gives res=2 and err=0. Without the macro -> err stays 0.
REQ-035 SETTLE=4, rst_n pulsed low during the second EXEC cycle -> no ack, all outputs at reset values; with req0 still high, ack0 arrives 5 cycles after the first post-reset grant cycle.
